// File: rtl/year_entry_if.sv
// Digit-entry / checker handshake bundle for year_entry.
// The slave side is the entry block; the master side drives digits and verdicts.
interface year_entry_if #(
    parameter int K = 13
);
    logic [3:0]          digit_in;
    logic                digit_valid;
    logic                enter;
    logic                clear;
    logic                chk_valid;
    logic                chk_fail;
    logic                chk_ok;
    logic signed [K-1:0] year_out;
    logic                year_valid;
    logic [2:0]          digit_count;
    logic [2:0]          status;

    modport master (
        output digit_in, digit_valid, enter, clear, chk_valid, chk_fail, chk_ok,
        input  year_out, year_valid, digit_count, status
    );

    modport slave (
        input  digit_in, digit_valid, enter, clear, chk_valid, chk_fail, chk_ok,
        output year_out, year_valid, digit_count, status
    );
endinterface

// File: rtl/year_entry.sv
// BCD digit entry that builds a signed year, hands it to the checker and
// latches the checker's verdict as a 3-bit status code.
//
// state     | meaning
// S_IDLE    | no entry in progress, year cleared
// S_COLLECT | accumulating digits
// S_SEND    | year presented, waiting for chk_valid
// S_DONE    | verdict latched, year held
// S_ERR     | bad digit or overflow, waits for clear
module year_entry #(
    parameter int k      = 13,
    parameter int digits = 4
) (
    input  logic         clk,
    input  logic         reset,
    year_entry_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SEND,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [k+3:0] YEAR_MAX  = {5'b0, {(k-1){1'b1}}};
    localparam logic [2:0]   DIGITS_C  = 3'(digits);

    state_t         state, state_nx;
    logic [k-1:0]   year_q, year_nx;
    logic [2:0]     count_q, count_nx;
    logic [2:0]     verdict_q, verdict_nx;

    logic [k-1:0]   acc_base;
    logic [k+3:0]   acc_wide;
    logic [k+3:0]   acc_next;
    logic [2:0]     count_base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            year_q    <= '0;
            count_q   <= '0;
            verdict_q <= '0;
        end else begin
            state     <= state_nx;
            year_q    <= year_nx;
            count_q   <= count_nx;
            verdict_q <= verdict_nx;
        end
    end

    // A digit arriving in IDLE or DONE starts a fresh entry from zero.
    always_comb begin
        acc_base   = (state == S_COLLECT) ? year_q : '0;
        count_base = (state == S_COLLECT) ? count_q : 3'd0;
        acc_wide   = {4'b0, acc_base};
        acc_next   = (acc_wide << 3) + (acc_wide << 1) + {{k{1'b0}}, bus.digit_in};
    end

    always_comb begin
        state_nx   = state;
        year_nx    = year_q;
        count_nx   = count_q;
        verdict_nx = verdict_q;

        if (bus.clear) begin
            state_nx = S_IDLE;
            year_nx  = '0;
            count_nx = '0;
        end else begin
            case (state)
                S_IDLE, S_COLLECT, S_DONE: begin
                    if (bus.digit_valid) begin
                        if (bus.digit_in > 4'd9 || acc_next > YEAR_MAX) begin
                            state_nx = S_ERR;
                        end else begin
                            year_nx  = acc_next[k-1:0];
                            count_nx = count_base + 3'd1;
                            if (count_nx == DIGITS_C || (bus.enter && state == S_COLLECT))
                                state_nx = S_SEND;
                            else
                                state_nx = S_COLLECT;
                        end
                    end else if (bus.enter && state == S_COLLECT && count_q != 3'd0) begin
                        state_nx = S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.chk_valid) begin
                        state_nx = S_DONE;
                        if (bus.chk_fail)
                            verdict_nx = 3'b100;
                        else if (bus.chk_ok)
                            verdict_nx = 3'b011;
                        else
                            verdict_nx = 3'b110;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_IDLE:    bus.status = 3'b000;
            S_COLLECT: bus.status = 3'b001;
            S_SEND:    bus.status = 3'b010;
            S_DONE:    bus.status = verdict_q;
            S_ERR:     bus.status = 3'b101;
            default:   bus.status = 3'b000;
        endcase
    end

    assign bus.year_out    = year_q;
    assign bus.digit_count = count_q;
    assign bus.year_valid  = (state == S_SEND);
endmodule

// File: tb/tb_year_entry.sv
// Scoreboard bench for year_entry: expected status events are queued by the
// stimulus and compared by a monitor whenever the DUT's status code changes.
module tb_year_entry;
    logic clk;
    logic reset;

    year_entry_if #(.K(13)) bus ();

    year_entry #(.k(13), .digits(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]  st;
        logic [12:0] yr;
        logic [2:0]  cnt;
        logic        vld;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [2:0] st, input int yr, input int cnt, input logic vld);
        exp_t e;
        e.st  = st;
        e.yr  = 13'(yr);
        e.cnt = 3'(cnt);
        e.vld = vld;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input int d);
        bus.digit_in    = 4'(d);
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic pulse_enter();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic verdict(input logic fail, input logic ok);
        bus.chk_valid = 1'b1;
        bus.chk_fail  = fail;
        bus.chk_ok    = ok;
        tick();
        bus.chk_valid = 1'b0;
        bus.chk_fail  = 1'b0;
        bus.chk_ok    = 1'b0;
    endtask

    // Monitor: every status transition must match the next queued expectation.
    logic [2:0] last_status = 3'b000;
    always @(negedge clk) begin
        if (bus.status !== last_status) begin
            if (q.size() == 0) begin
                check("unexpected_status_change", int'(bus.status), int'(last_status));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("status", int'(bus.status), int'(e.st));
                check("year_out", int'(bus.year_out), int'(e.yr));
                check("digit_count", int'(bus.digit_count), int'(e.cnt));
                check("year_valid", int'(bus.year_valid), int'(e.vld));
            end
            last_status = bus.status;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b0;
        bus.digit_in    = '0;
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;
        bus.chk_valid   = 1'b0;
        bus.chk_fail    = 1'b0;
        bus.chk_ok      = 1'b0;
        #12;
        check("rst_status", int'(bus.status), 0);
        check("rst_year", int'(bus.year_out), 0);
        check("rst_count", int'(bus.digit_count), 0);
        check("rst_valid", int'(bus.year_valid), 0);
        reset = 1'b1;
        tick();

        // 2019 with default verdict, checker answers in the first SEND cycle
        expect_ev(3'b001, 2, 1, 1'b0);
        send_digit(2);
        send_digit(0);
        send_digit(1);
        expect_ev(3'b010, 2019, 4, 1'b1);
        send_digit(9);
        expect_ev(3'b110, 2019, 4, 1'b0);
        verdict(1'b0, 1'b0);
        tick();
        expect_ev(3'b000, 0, 0, 1'b0);
        pulse_clear();

        // 198 finished early with enter, accepted
        expect_ev(3'b001, 1, 1, 1'b0);
        send_digit(1);
        send_digit(9);
        send_digit(8);
        expect_ev(3'b010, 198, 3, 1'b1);
        pulse_enter();
        expect_ev(3'b011, 198, 3, 1'b0);
        verdict(1'b0, 1'b1);
        expect_ev(3'b000, 0, 0, 1'b0);
        pulse_clear();

        // 5000 overflows on the last digit
        expect_ev(3'b001, 5, 1, 1'b0);
        send_digit(5);
        send_digit(0);
        send_digit(0);
        expect_ev(3'b101, 500, 3, 1'b0);
        send_digit(0);
        expect_ev(3'b000, 0, 0, 1'b0);
        pulse_clear();

        // invalid digit, later digits and enter ignored in ERR
        expect_ev(3'b001, 3, 1, 1'b0);
        send_digit(3);
        expect_ev(3'b101, 3, 1, 1'b0);
        send_digit(12);
        send_digit(5);
        pulse_enter();
        check("err_hold_year", int'(bus.year_out), 3);
        check("err_hold_count", int'(bus.digit_count), 1);
        expect_ev(3'b000, 0, 0, 1'b0);
        pulse_clear();

        // SEND holds through a stalled checker and ignores digits/enter
        expect_ev(3'b001, 1, 1, 1'b0);
        send_digit(1);
        send_digit(2);
        send_digit(3);
        expect_ev(3'b010, 1234, 4, 1'b1);
        send_digit(4);
        for (int i = 0; i < 5; i++) begin
            bus.digit_in    = 4'd7;
            bus.digit_valid = 1'b1;
            bus.enter       = (i == 2);
            tick();
            check("send_hold_year", int'(bus.year_out), 1234);
            check("send_hold_valid", int'(bus.year_valid), 1);
        end
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b0;
        expect_ev(3'b000, 0, 0, 1'b0);
        bus.clear     = 1'b1;
        bus.chk_valid = 1'b1;
        bus.chk_ok    = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.chk_valid = 1'b0;
        bus.chk_ok    = 1'b0;
        tick();
        check("clear_wins_status", int'(bus.status), 0);

        // async reset mid-entry, then a fresh entry with fail-priority verdict
        expect_ev(3'b001, 7, 1, 1'b0);
        send_digit(7);
        send_digit(7);
        #2;
        expect_ev(3'b000, 0, 0, 1'b0);
        reset = 1'b0;
        #1;
        check("async_rst_year", int'(bus.year_out), 0);
        check("async_rst_count", int'(bus.digit_count), 0);
        check("async_rst_status", int'(bus.status), 0);
        tick();
        reset = 1'b1;
        tick();
        expect_ev(3'b001, 1, 1, 1'b0);
        send_digit(1);
        send_digit(9);
        send_digit(9);
        expect_ev(3'b010, 1999, 4, 1'b1);
        send_digit(9);
        expect_ev(3'b100, 1999, 4, 1'b0);
        verdict(1'b1, 1'b1);
        tick();
        check("done_hold_year", int'(bus.year_out), 1999);
        expect_ev(3'b001, 4, 1, 1'b0);
        send_digit(4);
        expect_ev(3'b000, 0, 0, 1'b0);
        pulse_clear();

        repeat (3) tick();
        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/year_entry.md
# year_entry

Digit-entry front end that produces the 13-bit signed year consumed by the calculation/check stage. It accepts BCD digits one per strobe, accumulates them into a binary year (most significant digit first), and presents the year with a valid flag. It then holds that year until the checker returns its verdict, and latches the verdict into a 3-bit status code for the display/decoder side.

## Interface
- `k`, default 13: year width in bits, two's complement; must be ≥ 5.
- `digits`, default 4: maximum number of digits per entry.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low. All registers clear immediately while low.
- `digit_in`, input, 4: BCD digit, sampled when `digit_valid`=1.
- `digit_valid`, input, 1: one-cycle strobe; accept `digit_in`.
- `enter`, input, 1: one-cycle strobe; finish an entry early, with fewer than `digits` digits.
- `clear`, input, 1: synchronous abort back to IDLE.
- `chk_valid`, input, 1: checker verdict valid this cycle.
- `chk_fail`, input, 1: checker says the year is negative.
- `chk_ok`, input, 1: checker says the year differs from the default year 2019.
- `year_out`, output, k: signed accumulated year (registered).
- `year_valid`, output, 1: `year_out` is stable and awaiting a verdict.
- `digit_count`, output, 3: number of digits accepted in the current entry.
- `status`, output, 3: entry/verdict code.

## Operation
- States: IDLE, COLLECT, SEND, DONE, ERR.
- Status codes, driven by registered state:
  - IDLE = 000
  - COLLECT = 001
  - SEND = 010
  - DONE/accepted (`chk_ok`=1, `chk_fail`=0) = 011
  - DONE/rejected (`chk_fail`=1) = 100
  - DONE/default (`chk_ok`=0, `chk_fail`=0) = 110
  - ERR = 101
- Digit accept (IDLE, COLLECT or DONE):
  - Compute acc_next = acc*10 + digit as (acc<<3)+(acc<<1)+digit, in k+4 bits.
  - Update `year_out` and increment `digit_count`.
  - From IDLE or DONE, acc restarts at 0 before the digit is applied (new entry); the status code becomes 001.
- Invalid digit (`digit_in` > 9): digit discarded and the state goes to ERR; `year_out` and `digit_count` are held.
- Overflow: if acc_next > 2^(k-1)-1 (4095 at k=13), go to ERR; `year_out` is held. A sign-bit wrap is never exposed.
- COLLECT → SEND when:
  - the accepted digit makes `digit_count` = `digits`, or
  - `enter`=1 with `digit_count` ≥ 1.
- `enter` in IDLE, or with `digit_count`=0, is ignored.
- SEND:
  - `year_valid`=1 and `year_out` frozen.
  - `digit_valid` and `enter` are ignored.
  - On an edge where `chk_valid`=1, latch the verdict and go to DONE, with `year_valid`=0 next cycle.
- DONE: `year_out` and the verdict are held until the next digit or `clear`.
- ERR: held until `clear`; `digit_valid` and `enter` are ignored.
- `chk_valid` outside SEND is ignored. `chk_fail` takes priority over `chk_ok`.
- `clear` in any state → IDLE: `year_out`=0, `digit_count`=0, `year_valid`=0. `clear` wins over a simultaneous `digit_valid`, `enter` or `chk_valid`.
- Only positive years are entered. `chk_fail` is expected to stay 0 but is handled as specified.

## Timing
- Reset values (async, while `reset`=0): state IDLE, `year_out`=0, `year_valid`=0, `digit_count`=0, `status`=000.
- Reset asserted mid-entry or in SEND discards everything; there is no pending verdict after release.
- Digit latency:
  - `year_out` and `digit_count` update on the edge that samples `digit_valid`.
  - Visible the following cycle.
- `year_valid` rises on the edge that accepts the last digit or `enter`. It is high in the first cycle after that edge.
- Handshake: `year_valid` stays high until the edge that samples `chk_valid`=1 (inclusive). It is low the cycle after.
  - A `chk_valid` that coincides with the first `year_valid` cycle completes the transfer; minimum SEND occupancy is 1 cycle.
- `status` changes on the same edge as the state; it is 1 cycle after the causing input.
- Back-to-back `digit_valid` every cycle is supported: one digit per cycle.

## Test plan
- Enter 2,0,1,9 on consecutive cycles:
  - `year_out`=2019 (13'h07E3) and `year_valid`=1 the cycle after the 4th digit.
  - `chk_valid`=1 with `chk_ok`=0, `chk_fail`=0 gives `status`=110 and `year_valid`=0 one cycle later.
- Enter 1,9,8 then `enter`: `year_out`=198, `digit_count`=3, `year_valid`=1. `chk_ok`=1 gives `status`=011.
- Enter 5,0,0,0: the 4th digit overflows (5000 > 4095), giving `status`=101 and `year_out`=500 held. `clear` gives `status`=000 and `year_out`=0.
- Enter 3 then digit 12: `status`=101 and `year_out`=3. Further digits are ignored until `clear`.
- In SEND:
  - Hold `chk_valid`=0 for 5 cycles: `year_valid` stays 1 and `year_out` stays stable.
  - Drive `digit_valid` during that window: no effect.
  - Then `clear` together with `chk_valid`=1: IDLE, `status`=000.
- Drop `reset` low mid-entry after 2 digits, asynchronously between edges: outputs are 0 immediately. After release, 4 new digits produce the new year only.
